// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with enable prescaler, parallel load,
// synchronous clear, wrap or saturate at the limits, a terminal-count pulse
// and a sticky overflow flag.
module param_up_down_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic             Clock,
  input  logic             ClearN,
  input  logic             Enable,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             SyncClear,
  output logic [WIDTH-1:0] Count,
  output logic             Zero,
  output logic             TerminalCount,
  output logic             Overflow
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL = {WIDTH{1'b0}};

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step_c;
  logic             boundary_c;

  if (PRESCALE > 1) begin : g_prescale
    localparam int unsigned PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] pre_q, pre_d;
    logic            pre_step_c;

    // Prescaler: clear/load restart the period; a step fires on the last phase.
    always_comb begin
      pre_d      = pre_q;
      pre_step_c = 1'b0;
      if (SyncClear || Load) begin
        pre_d = '0;
      end else if (Enable) begin
        if (pre_q == PS_LAST) begin
          pre_d      = '0;
          pre_step_c = 1'b1;
        end else begin
          pre_d = pre_q + PS_W'(1);
        end
      end
    end

    // Prescaler phase register.
    always_ff @(posedge Clock or negedge ClearN) begin
      if (!ClearN) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_d;
      end
    end

    assign step_c = pre_step_c;
  end else begin : g_no_prescale
    // Without a prescaler every enabled clock that is not a clear/load steps.
    assign step_c = Enable & ~SyncClear & ~Load;
  end

  // A step from this value in the current direction crosses a limit.
  assign boundary_c = Up ? (count_q == MAX_VAL) : (count_q == MIN_VAL);

  // Next-state: SyncClear beats Load beats a counting step.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (SyncClear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (Load) begin
      count_d = LoadValue;
    end else if (step_c) begin
      if (boundary_c) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (SATURATE == 0) begin
          count_d = Up ? MIN_VAL : MAX_VAL;
        end
      end else begin
        count_d = Up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
      end
    end
  end

  // Counter and flag registers.
  always_ff @(posedge Clock or negedge ClearN) begin
    if (!ClearN) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Count         = count_q;
  assign TerminalCount = tc_q;
  assign Overflow      = ovf_q;
  assign Zero          = (count_q == MIN_VAL);

endmodule

// File: tb/tb_param_up_down_counter.sv
// Directed bench for param_up_down_counter: wrap, saturate, prescaled and
// async-reset instances driven from one linear stimulus sequence.
module tb_param_up_down_counter;

  logic Clock;
  logic ClearN;

  logic       a_en, a_up, a_ld, a_sc;
  logic [7:0] a_lv, a_cnt;
  logic       a_zero, a_tc, a_ovf;

  logic       b_en, b_up, b_ld, b_sc;
  logic [7:0] b_lv, b_cnt;
  logic       b_zero, b_tc, b_ovf;

  logic       c_en, c_up, c_ld, c_sc;
  logic [3:0] c_lv, c_cnt;
  logic       c_zero, c_tc, c_ovf;

  logic       d_en, d_up, d_ld, d_sc;
  logic [7:0] d_lv, d_cnt;
  logic       d_zero, d_tc, d_ovf;

  int checks = 0;
  int errors = 0;

  param_up_down_counter #(.WIDTH(8), .PRESCALE(1), .SATURATE(0)) u_wrap (
    .Clock(Clock), .ClearN(ClearN), .Enable(a_en), .Up(a_up), .Load(a_ld),
    .LoadValue(a_lv), .SyncClear(a_sc), .Count(a_cnt), .Zero(a_zero),
    .TerminalCount(a_tc), .Overflow(a_ovf));

  param_up_down_counter #(.WIDTH(8), .PRESCALE(1), .SATURATE(1)) u_sat (
    .Clock(Clock), .ClearN(ClearN), .Enable(b_en), .Up(b_up), .Load(b_ld),
    .LoadValue(b_lv), .SyncClear(b_sc), .Count(b_cnt), .Zero(b_zero),
    .TerminalCount(b_tc), .Overflow(b_ovf));

  param_up_down_counter #(.WIDTH(4), .PRESCALE(3), .SATURATE(0)) u_pre3 (
    .Clock(Clock), .ClearN(ClearN), .Enable(c_en), .Up(c_up), .Load(c_ld),
    .LoadValue(c_lv), .SyncClear(c_sc), .Count(c_cnt), .Zero(c_zero),
    .TerminalCount(c_tc), .Overflow(c_ovf));

  param_up_down_counter #(.WIDTH(8), .PRESCALE(4), .SATURATE(0)) u_pre4 (
    .Clock(Clock), .ClearN(ClearN), .Enable(d_en), .Up(d_up), .Load(d_ld),
    .LoadValue(d_lv), .SyncClear(d_sc), .Count(d_cnt), .Zero(d_zero),
    .TerminalCount(d_tc), .Overflow(d_ovf));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    logic [7:0] sat_cnt [5];
    logic       sat_tc  [5];

    ClearN = 1'b0;
    {a_en, a_up, a_ld, a_sc} = '0; a_lv = '0;
    {b_en, b_up, b_ld, b_sc} = '0; b_lv = '0;
    {c_en, c_up, c_ld, c_sc} = '0; c_lv = '0;
    {d_en, d_up, d_ld, d_sc} = '0; d_lv = '0;

    // Reset state
    #2;
    chk("rst_a_cnt", 32'(a_cnt), 32'h0);
    chk("rst_a_zero", 32'(a_zero), 32'h1);
    chk("rst_a_tc", 32'(a_tc), 32'h0);
    chk("rst_a_ovf", 32'(a_ovf), 32'h0);
    chk("rst_b_cnt", 32'(b_cnt), 32'h0);
    chk("rst_c_cnt", 32'(c_cnt), 32'h0);
    chk("rst_d_cnt", 32'(d_cnt), 32'h0);
    c_en = 1'b1;
    c_up = 1'b1;
    #1 ClearN = 1'b1;

    // Prescale 3: steps on edges 3 and 6, Enable low over edges 5,6 delays to 8
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("pre3_cnt", 32'(c_cnt), 32'(e / 3));
    end
    c_en = 1'b0;
    tick(); chk("pre3_hold5", 32'(c_cnt), 32'h1);
    tick(); chk("pre3_hold6", 32'(c_cnt), 32'h1);
    c_en = 1'b1;
    tick(); chk("pre3_e7", 32'(c_cnt), 32'h1);
    tick(); chk("pre3_e8", 32'(c_cnt), 32'h2);
    chk("pre3_tc", 32'(c_tc), 32'h0);
    c_en = 1'b0;

    // Wrap up-count through 256 steps
    a_en = 1'b1;
    a_up = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      tick();
      chk("up_cnt", 32'(a_cnt), 32'(k % 256));
      chk("up_tc", 32'(a_tc), 32'(k == 256));
      chk("up_ovf", 32'(a_ovf), 32'(k == 256));
      chk("up_zero", 32'(a_zero), 32'(k == 256));
    end
    tick();
    chk("up_after_cnt", 32'(a_cnt), 32'h1);
    chk("up_after_tc", 32'(a_tc), 32'h0);
    chk("up_after_ovf", 32'(a_ovf), 32'h1);
    a_en = 1'b0;
    tick();
    chk("en0_hold", 32'(a_cnt), 32'h1);

    // Down wrap
    a_sc = 1'b1;
    tick();
    chk("sc_cnt", 32'(a_cnt), 32'h0);
    chk("sc_ovf", 32'(a_ovf), 32'h0);
    a_sc = 1'b0;
    a_ld = 1'b1;
    a_lv = 8'h01;
    tick();
    chk("ld01_cnt", 32'(a_cnt), 32'h01);
    a_ld = 1'b0;
    a_en = 1'b1;
    a_up = 1'b0;
    tick(); chk("dn_cnt0", 32'(a_cnt), 32'h00); chk("dn_tc0", 32'(a_tc), 32'h0);
    tick(); chk("dn_cnt1", 32'(a_cnt), 32'hFF); chk("dn_tc1", 32'(a_tc), 32'h1);
    chk("dn_ovf1", 32'(a_ovf), 32'h1);
    tick(); chk("dn_cnt2", 32'(a_cnt), 32'hFE); chk("dn_tc2", 32'(a_tc), 32'h0);
    chk("dn_ovf2", 32'(a_ovf), 32'h1);

    // Priority: Load over Enable, then SyncClear over Load
    a_up = 1'b1;
    a_ld = 1'b1;
    a_lv = 8'h40;
    tick();
    chk("prio_ld_cnt", 32'(a_cnt), 32'h40);
    chk("prio_ld_ovf", 32'(a_ovf), 32'h1);
    chk("prio_ld_tc", 32'(a_tc), 32'h0);
    a_sc = 1'b1;
    tick();
    chk("prio_sc_cnt", 32'(a_cnt), 32'h00);
    chk("prio_sc_ovf", 32'(a_ovf), 32'h0);
    {a_sc, a_ld, a_en} = '0;

    // Saturate up from FD
    sat_cnt = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    sat_tc  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    b_ld = 1'b1;
    b_lv = 8'hFD;
    tick();
    chk("sat_ld", 32'(b_cnt), 32'hFD);
    b_ld = 1'b0;
    b_en = 1'b1;
    b_up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_cnt", 32'(b_cnt), 32'(sat_cnt[i]));
      chk("sat_tc", 32'(b_tc), 32'(sat_tc[i]));
      chk("sat_ovf", 32'(b_ovf), 32'(sat_tc[i]));
    end
    b_en = 1'b0;
    b_sc = 1'b1;
    tick();
    chk("sat_sc_cnt", 32'(b_cnt), 32'h0);
    chk("sat_sc_ovf", 32'(b_ovf), 32'h0);
    chk("sat_sc_tc", 32'(b_tc), 32'h0);
    b_sc = 1'b0;
    b_en = 1'b1;
    b_up = 1'b0;
    tick();
    chk("sat_dn_cnt", 32'(b_cnt), 32'h0);
    chk("sat_dn_tc", 32'(b_tc), 32'h1);
    chk("sat_dn_ovf", 32'(b_ovf), 32'h1);
    b_en = 1'b0;
    tick();
    chk("sat_idle_tc", 32'(b_tc), 32'h0);
    chk("sat_idle_ovf", 32'(b_ovf), 32'h1);

    // Async reset mid-count: prescaler of u_pre4 at phase 1, u_wrap with flags set
    d_ld = 1'b1;
    d_lv = 8'h37;
    tick();
    chk("d_ld", 32'(d_cnt), 32'h37);
    d_ld = 1'b0;
    d_en = 1'b1;
    d_up = 1'b1;
    tick();
    chk("d_phase1", 32'(d_cnt), 32'h37);
    d_en = 1'b0;
    a_ld = 1'b1;
    a_lv = 8'hFF;
    tick();
    a_ld = 1'b0;
    a_en = 1'b1;
    a_up = 1'b1;
    tick();
    chk("ar_pre_cnt", 32'(a_cnt), 32'h0);
    chk("ar_pre_tc", 32'(a_tc), 32'h1);
    a_en = 1'b0;
    #2 ClearN = 1'b0;
    #1;
    chk("ar_a_tc", 32'(a_tc), 32'h0);
    chk("ar_a_ovf", 32'(a_ovf), 32'h0);
    chk("ar_a_zero", 32'(a_zero), 32'h1);
    chk("ar_b_ovf", 32'(b_ovf), 32'h0);
    chk("ar_d_cnt", 32'(d_cnt), 32'h0);
    chk("ar_d_zero", 32'(d_zero), 32'h1);
    #1 ClearN = 1'b1;
    d_en = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("ar_restart", 32'(d_cnt), 32'(e / 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
